// File: rtl/dec_pkg.sv
// dec_pkg: shared state encoding, mode constants and one-hot helper for the scan decoder.
package dec_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_e;
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN = 1'b1;
    function automatic logic [31:0] onehot(input int unsigned addr, input int unsigned n);
        return (addr < n) ? (32'd1 << addr) : 32'd0;
    endfunction
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: combinational address-to-one-hot with an in-range flag.
module onehot_dec #(
    parameter int AW = 2,
    parameter int NOUT = 4
) (
    input  logic [AW-1:0]   addr_i,
    output logic [NOUT-1:0] oh_o,
    output logic            ok_o
);
    always_comb begin
        ok_o = 32'(addr_i) < NOUT;
        oh_o = ok_o ? (NOUT'(1) << addr_i) : '0;
    end
endmodule

// File: rtl/dec_scan.sv
// dec_scan: registered one-hot decoder with enable, direct/scan modes and break-before-make blanking.
module dec_scan import dec_pkg::*; #(
    parameter int AW = 2,
    parameter int NOUT = 4,
    parameter int DWELL = 4,
    parameter int BBM = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [AW-1:0]   addr_in,
    input  logic            addr_ld,
    output logic [NOUT-1:0] dout,
    output logic [AW-1:0]   cur_addr,
    output logic            err,
    output logic            wrap
);
    localparam int CW = $clog2(DWELL + 1);
    state_e          st_q, st_d;
    logic [AW-1:0]   addr_q, addr_d, nxt;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NOUT-1:0] dout_q, dout_d, ld_oh;
    logic            err_q, err_d, wrap_q, wrap_d, wp_q, wp_d;
    logic            ld_ok, in_rng, expire;
    onehot_dec #(.AW(AW), .NOUT(NOUT)) u_dec (.addr_i(addr_in), .oh_o(ld_oh), .ok_o(in_rng));
    assign ld_ok = addr_ld & in_rng;
    assign expire = (mode == MODE_SCAN) && (cnt_q == CW'(DWELL - 1));
    assign nxt = (addr_q == AW'(NOUT - 1)) ? '0 : addr_q + AW'(1);
    // wp_q remembers that the pending BLANK leads into a wrap to address 0
    always_comb begin
        st_d = st_q;
        addr_d = addr_q;
        cnt_d = cnt_q;
        err_d = addr_ld & ~in_rng;
        wrap_d = 1'b0;
        wp_d = wp_q;
        if (!en) begin
            st_d = IDLE;
            cnt_d = '0;
            wp_d = 1'b0;
            if (ld_ok) addr_d = addr_in;
        end else if (st_q == ACTIVE) begin
            if (ld_ok) begin
                cnt_d = '0;
                addr_d = addr_in;
                wp_d = 1'b0;
                if (addr_in != addr_q && BBM != 0) st_d = BLANK;
            end else if (mode == MODE_DIRECT) begin
                cnt_d = '0;
            end else if (expire) begin
                cnt_d = '0;
                addr_d = nxt;
                if (BBM != 0) begin
                    st_d = BLANK;
                    wp_d = (nxt == '0);
                end else begin
                    wrap_d = (nxt == '0);
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            st_d = ACTIVE;
            cnt_d = '0;
            wp_d = 1'b0;
            wrap_d = (st_q == BLANK) & wp_q & ~ld_ok;
            if (ld_ok) addr_d = addr_in;
        end
        dout_d = (st_d == ACTIVE) ? (ld_ok ? ld_oh : NOUT'(onehot(32'(addr_d), NOUT))) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= IDLE;
            addr_q <= '0;
            cnt_q <= '0;
            dout_q <= '0;
            err_q <= 1'b0;
            wrap_q <= 1'b0;
            wp_q <= 1'b0;
        end else begin
            st_q <= st_d;
            addr_q <= addr_d;
            cnt_q <= cnt_d;
            dout_q <= dout_d;
            err_q <= err_d;
            wrap_q <= wrap_d;
            wp_q <= wp_d;
        end
    end
    assign dout = dout_q;
    assign cur_addr = addr_q;
    assign err = err_q;
    assign wrap = wrap_q;
endmodule

// File: doc/dec_scan.md
Name: dec_scan

Overview:
Parametrised binary-to-one-hot decoder with registered outputs, enable, and break-before-make blanking. Two modes:
- Direct: a host loads an address.
- Scan: an internal sequencer steps through all valid outputs, each held for a programmable dwell time.

It drives row/digit selects and chip-selects that must never overlap. It is the clocked, generalised successor to the team's combinational enable decoders.

Parameters:
AW, 2, address width in bits
NOUT, 4, number of one-hot outputs; must satisfy 2 <= NOUT <= 2**AW
DWELL, 4, cycles each output stays asserted in scan mode; >= 1
BBM, 1, 1 = insert one all-zero blanking cycle between different active outputs; 0 = switch directly

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  output enable; 0 forces dout to zero
mode  in  1  0 = direct, 1 = scan
addr_in  in  AW  address to load
addr_ld  in  1  one-cycle load strobe for addr_in
dout  out  NOUT  registered one-hot select; all zero when idle or blanking
cur_addr  out  AW  registered current/pending address
err  out  1  one-cycle pulse: last load had addr_in >= NOUT
wrap  out  1  one-cycle pulse when scan wraps from NOUT-1 to 0

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high. While rst = 1: dout = 0, cur_addr = 0, err = 0, wrap = 0, dwell counter = 0, state = IDLE.
- States: IDLE (dout = 0), ACTIVE (dout = onehot(cur_addr)), BLANK (dout = 0; new address pending).
- Invariant: popcount(dout) <= 1 in every cycle, including across reset release and mode changes.
- IDLE -> ACTIVE on the first edge with en = 1. No blank cycle, because dout is already zero.
- Any state -> IDLE on the edge where en = 0:
  - dout goes to 0 after that edge.
  - cur_addr is retained.
  - dwell counter is cleared.
- Loads (addr_ld = 1):
  - addr_in >= NOUT: err = 1 for the next cycle; cur_addr and dout are unchanged.
  - Valid addr_in while en = 0: updates cur_addr only.
  - Valid addr_in equal to cur_addr while ACTIVE: no output change; dwell counter restarts.
  - Valid, different addr_in while ACTIVE with BBM = 1: ACTIVE -> BLANK for exactly one cycle, then ACTIVE with the new one-hot. Latency: strobe sampled at edge k gives dout = 0 after edge k and the new one-hot after edge k+1.
  - Same case with BBM = 0: new one-hot after edge k.
  - Load during BLANK: replaces the pending address; BLANK still ends on the next edge.
- Scan mode, ACTIVE:
  - Dwell counter runs 0..DWELL-1.
  - At DWELL-1: next = (cur_addr == NOUT-1) ? 0 : cur_addr + 1, entered through BLANK if BBM = 1.
  - Each address is asserted for exactly DWELL cycles; the period is NOUT*(DWELL+BBM).
  - wrap pulses in the first ACTIVE cycle of address 0 after a wrap. It does not pulse on the initial entry from IDLE or reset.
- Direct mode: the dwell counter is held at 0; the address changes only on loads.
- Simultaneous load and dwell expiry: the load wins; the scan step is discarded; the counter restarts.
- Mode change: takes effect at the next edge. Entering scan clears the dwell counter. Leaving scan freezes the current address active.
- Arithmetic: the address increment is modulo NOUT, not 2**AW. The dwell counter width is $clog2(DWELL+1).
- Reset asserted mid-operation clears everything asynchronously. The first ACTIVE cycle after release requires en = 1 and shows onehot(0).

Decomposition:
- Shared package dec_pkg holds:
  - state enum {IDLE, ACTIVE, BLANK}
  - MODE_DIRECT = 0, MODE_SCAN = 1
  - function onehot(addr, NOUT)
- Sub-module onehot_dec (parameters AW and NOUT): combinational address-to-one-hot with an in-range flag. It is instantiated once for dout and reused for the err range check.

Test Plan:
All scenarios use AW = 2, NOUT = 4, DWELL = 3, BBM = 1 unless stated otherwise.
1. Reset, then en = 1, mode = 0 -> dout = 0001 after the first edge; err = 0; wrap = 0.
2. Direct load addr_in = 2 while ACTIVE at 0 -> dout 0000 for one cycle, then 0100; cur_addr = 2. With BBM = 0 -> 0100 immediately.
3. NOUT = 3, load addr_in = 3 -> err = 1 for exactly one cycle; dout and cur_addr unchanged.
4. Scan from 0 -> dout 0001×3, 0000, 0010×3, 0000, 0100×3, 0000, 1000×3, 0000, 0001 with wrap = 1 in that cycle only.
5. Scan at addr 1, drop en -> dout 0000 next edge. Re-raise en 5 cycles later -> 0010 directly with no blank, then a full 3-cycle dwell.
6. Load addr_in = 3 on the edge where dwell expires at addr 1 -> 0000 then 1000; address 2 never appears. Separately, assert rst mid-BLANK -> all outputs 0 immediately, with no glitch to two-hot.
